// File: rtl/feature_stager_pkg.sv
// ---------------------------------------------------------------------------
// feature_stager_pkg
// Shared constants and types for the double-buffered feature staging buffer.
//   NUM_BANKS     : number of register banks (one filling, one driving)
//   ELEMENT_WIDTH : default element width used by element_t
//   count_t       : number of committed banks, 0..NUM_BANKS
//   COUNT_FULL    : count value at which no fill bank is available
//   element_t     : one feature element at the default width
// ---------------------------------------------------------------------------
package feature_stager_pkg;

    localparam int NUM_BANKS     = 2;
    localparam int ELEMENT_WIDTH = 8;

    typedef logic [1:0] count_t;
    typedef logic [ELEMENT_WIDTH-1:0] element_t;

    localparam count_t COUNT_FULL = 2'd2;

endpackage

// File: rtl/feature_bank.sv
// ---------------------------------------------------------------------------
// feature_bank
// One numElements x elementWidth register array used as a single bank.
// Ports:
//   clk, nrst : clock, asynchronous active-low reset (clears the array)
//   wr_en     : perform the masked multi-element write this cycle
//   addr      : element index of beat element 0
//   data      : beat payload, element j at [j*elementWidth +: elementWidth]
//   mask      : per-element write enable
//   clear     : synchronous zeroing of the whole array
//   rd_data   : full-vector read, element i at [i*elementWidth +: elementWidth]
//   oob       : a masked element of the current write falls past the array
// ---------------------------------------------------------------------------
module feature_bank #(
    parameter int inputWidth   = 256,
    parameter int elementWidth = 8,
    parameter int numElements  = 256,
    parameter int addrWidth    = $clog2(numElements)
) (
    input  logic                                 clk,
    input  logic                                 nrst,
    input  logic                                 wr_en,
    input  logic [addrWidth-1:0]                 addr,
    input  logic [inputWidth-1:0]                data,
    input  logic [inputWidth/elementWidth-1:0]   mask,
    input  logic                                 clear,
    output logic [numElements*elementWidth-1:0]  rd_data,
    output logic                                 oob
);

    localparam int elemsPerBeat = inputWidth / elementWidth;
    localparam int IDX_W        = addrWidth + 1;
    localparam logic [IDX_W-1:0] LIMIT = IDX_W'(numElements);

    logic [elementWidth-1:0] mem [numElements];
    logic [IDX_W-1:0]        idx [elemsPerBeat];
    logic [elemsPerBeat-1:0] hit;
    logic [elemsPerBeat-1:0] miss;

    // Element indices carry one extra bit so a beat running past the end
    // of the array is detected instead of wrapping back to element 0.
    always_comb begin
        idx  = '{default: '0};
        hit  = '0;
        miss = '0;
        for (int j = 0; j < elemsPerBeat; j++) begin
            idx[j]  = {1'b0, addr} + IDX_W'(j);
            hit[j]  = wr_en && mask[j] && (idx[j] <  LIMIT);
            miss[j] = wr_en && mask[j] && (idx[j] >= LIMIT);
        end
    end

    assign oob = |miss;

    // Clear is applied first so that a write in the same cycle would win;
    // the top level never writes and clears the same bank together.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < numElements; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (clear) begin
                for (int i = 0; i < numElements; i++) begin
                    mem[i] <= '0;
                end
            end
            for (int j = 0; j < elemsPerBeat; j++) begin
                if (hit[j]) begin
                    mem[idx[j][addrWidth-1:0]] <= data[j*elementWidth +: elementWidth];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < numElements; i++) begin
            rd_data[i*elementWidth +: elementWidth] = mem[i];
        end
    end

endmodule

// File: rtl/feature_stager.sv
// ---------------------------------------------------------------------------
// feature_stager
// Double-buffered staging buffer feeding one feature vector per array
// operation. Masked multi-element write beats fill one bank while the other
// bank drives the array row drivers.
// Ports:
//   clk, nrst    : clock, asynchronous active-low reset
//   in_valid_i   : write beat valid
//   in_ready_o   : a fill bank is available (fewer than two committed)
//   data_i       : beat payload, element j at [j*elementWidth +: elementWidth]
//   addr_i       : element index of beat element 0
//   mask_i       : per-element write enable
//   commit_i     : accepted beat closes the fill bank
//   out_valid_o  : read bank holds a committed vector
//   out_ready_i  : array consumed the vector; releases and zeroes the bank
//   data_o       : read-bank contents, element i at [i*elementWidth +: elementWidth]
//   err_o        : sticky flag, a masked element addressed past the vector
// ---------------------------------------------------------------------------
module feature_stager
    import feature_stager_pkg::*;
#(
    parameter int inputWidth   = 256,
    parameter int elementWidth = 8,
    parameter int numElements  = 256,
    parameter int addrWidth    = $clog2(numElements)
) (
    input  logic                                 clk,
    input  logic                                 nrst,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic [inputWidth-1:0]                data_i,
    input  logic [addrWidth-1:0]                 addr_i,
    input  logic [inputWidth/elementWidth-1:0]   mask_i,
    input  logic                                 commit_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [numElements*elementWidth-1:0]  data_o,
    output logic                                 err_o
);

    logic   wr_bank;
    logic   wr_bank_d;
    logic   rd_bank;
    logic   rd_bank_d;
    count_t count;
    count_t count_d;
    logic   err_q;
    logic   err_d;

    logic   accept;
    logic   commit_fire;
    logic   release_fire;

    logic [NUM_BANKS-1:0]                bank_oob;
    logic [numElements*elementWidth-1:0] bank_data [NUM_BANKS];

    // Handshake outputs come straight from registered state, so a release
    // only frees the fill side from the following cycle.
    assign in_ready_o  = (count < COUNT_FULL);
    assign out_valid_o = (count != count_t'(0));

    // Next-state: a commit adds a bank, a release removes one; both in the
    // same cycle just swap both pointers and leave count alone.
    always_comb begin
        accept       = in_valid_i && in_ready_o;
        commit_fire  = accept && commit_i;
        release_fire = out_valid_o && out_ready_i;
        wr_bank_d    = wr_bank;
        rd_bank_d    = rd_bank;
        count_d      = count;
        err_d        = err_q | (|bank_oob);

        if (commit_fire) begin
            wr_bank_d = ~wr_bank;
        end
        if (release_fire) begin
            rd_bank_d = ~rd_bank;
        end
        case ({commit_fire, release_fire})
            2'b10:   count_d = count + count_t'(1);
            2'b01:   count_d = count - count_t'(1);
            default: count_d = count;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            count   <= '0;
            err_q   <= 1'b0;
        end else begin
            wr_bank <= wr_bank_d;
            rd_bank <= rd_bank_d;
            count   <= count_d;
            err_q   <= err_d;
        end
    end

    assign err_o = err_q;

    // The fill bank is never the bank being released: when a release is
    // possible count is at least 1, so the pointers differ whenever writes
    // are also possible.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        feature_bank #(
            .inputWidth   (inputWidth),
            .elementWidth (elementWidth),
            .numElements  (numElements),
            .addrWidth    (addrWidth)
        ) u_bank (
            .clk     (clk),
            .nrst    (nrst),
            .wr_en   (accept && (wr_bank == 1'(b))),
            .addr    (addr_i),
            .data    (data_i),
            .mask    (mask_i),
            .clear   (release_fire && (rd_bank == 1'(b))),
            .rd_data (bank_data[b]),
            .oob     (bank_oob[b])
        );
    end

    assign data_o = bank_data[rd_bank];

endmodule

// File: tb/tb_feature_stager.sv
// ---------------------------------------------------------------------------
// tb_feature_stager
// Self-checking bench for feature_stager. The stimulus side keeps a model of
// the vector being filled and pushes every committed vector into a queue;
// an independent monitor compares handshake, error flag and data_o against
// the head of that queue every cycle and pops it when the array releases.
// ---------------------------------------------------------------------------
module tb_feature_stager;

    localparam int IW  = 256;
    localparam int EW  = 8;
    localparam int NE  = 256;
    localparam int AW  = 8;
    localparam int EPB = IW / EW;
    localparam int OW  = NE * EW;

    logic           clk = 1'b0;
    logic           nrst = 1'b0;
    logic           in_valid_i = 1'b0;
    logic [IW-1:0]  data_i = '0;
    logic [AW-1:0]  addr_i = '0;
    logic [EPB-1:0] mask_i = '0;
    logic           commit_i = 1'b0;
    logic           out_ready_i = 1'b0;
    logic           in_ready_o;
    logic           out_valid_o;
    logic [OW-1:0]  data_o;
    logic           err_o;

    feature_stager #(
        .inputWidth   (IW),
        .elementWidth (EW),
        .numElements  (NE),
        .addrWidth    (AW)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .data_i      (data_i),
        .addr_i      (addr_i),
        .mask_i      (mask_i),
        .commit_i    (commit_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .data_o      (data_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    logic [OW-1:0] exp_q [$];
    logic [OW-1:0] fill_vec = '0;
    logic          exp_err = 1'b0;
    int            vec_count = 0;
    int            miscompares = 0;

    task automatic check_output(input string name, input logic act, input logic exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_vector(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        bit reported;
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            reported = 1'b0;
            for (int i = 0; i < NE; i++) begin
                if (!reported && act[i*EW +: EW] !== exp[i*EW +: EW]) begin
                    $display("[TB] FAIL %s elem %0d: got %h want %h at %0t",
                             name, i, act[i*EW +: EW], exp[i*EW +: EW], $time);
                    reported = 1'b1;
                end
            end
        end
    endtask

    // Reference model: element addr+j takes byte j when masked; anything
    // past the vector end is dropped and raises the sticky error. A commit
    // closes the vector and the next fill starts from all zeros.
    task automatic model_accept(input logic [AW-1:0] addr, input logic [IW-1:0] data,
                                input logic [EPB-1:0] mask, input logic commit);
        int idx;
        for (int j = 0; j < EPB; j++) begin
            if (mask[j]) begin
                idx = int'(addr) + j;
                if (idx < NE) fill_vec[idx*EW +: EW] = data[j*EW +: EW];
                else          exp_err = 1'b1;
            end
        end
        if (commit) begin
            exp_q.push_back(fill_vec);
            fill_vec = '0;
        end
    endtask

    // Drive one beat from a falling edge, wait (bounded) for acceptance,
    // and record it in the model once the accepting rising edge has passed.
    task automatic apply_stimulus(input logic [AW-1:0] addr, input logic [IW-1:0] data,
                                  input logic [EPB-1:0] mask, input logic commit, input logic rel);
        int   waited = 0;
        logic taken;
        in_valid_i  = 1'b1;
        addr_i      = addr;
        data_i      = data;
        mask_i      = mask;
        commit_i    = commit;
        out_ready_i = rel;
        while (!in_ready_o && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        taken = in_ready_o;
        if (!taken) begin
            vec_count++;
            miscompares++;
            $display("[TB] FAIL ready_timeout: in_ready got 0 want 1 within 20 cycles at %0t", $time);
        end
        @(negedge clk);
        in_valid_i  = 1'b0;
        commit_i    = 1'b0;
        out_ready_i = 1'b0;
        if (taken) model_accept(addr, data, mask, commit);
    endtask

    task automatic release_vector();
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
    endtask

    task automatic random_vector(input logic commit_last);
        int beats;
        beats = $urandom_range(1, 3);
        for (int b = 0; b < beats; b++) begin
            apply_stimulus(AW'($urandom_range(0, NE - EPB)), {8{$urandom}}, $urandom,
                           commit_last && (b == beats - 1), 1'b0);
        end
    endtask

    task automatic do_reset();
        in_valid_i  = 1'b0;
        commit_i    = 1'b0;
        out_ready_i = 1'b0;
        nrst        = 1'b0;
        exp_q.delete();
        fill_vec    = '0;
        exp_err     = 1'b0;
        #2;
        check_output("reset_in_ready", in_ready_o, 1'b1);
        check_output("reset_out_valid", out_valid_o, 1'b0);
        check_output("reset_err", err_o, 1'b0);
        check_vector("reset_data_o", data_o, '0);
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
    endtask

    // Monitor: sampled just after each falling edge, well away from the
    // rising edge where the DUT updates.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            check_output("in_ready", in_ready_o, exp_q.size() < 2);
            check_output("out_valid", out_valid_o, exp_q.size() > 0);
            check_output("err", err_o, exp_err);
            if (exp_q.size() > 0) begin
                check_vector("data_o", data_o, exp_q[0]);
                if (out_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [IW-1:0] beat;
        logic          rel;

        @(negedge clk);
        do_reset();

        // Eight full beats with element value = index, committed on the last.
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < EPB; j++) beat[j*EW +: EW] = 8'(k*EPB + j);
            apply_stimulus(AW'(k*EPB), beat, '1, k == 7, 1'b0);
        end
        repeat (2) @(negedge clk);
        release_vector();

        // Fill both banks with no consumer, then try to push while full.
        random_vector(1'b1);
        random_vector(1'b1);
        @(negedge clk);
        in_valid_i = 1'b1;
        addr_i     = AW'(250);
        data_i     = {8{$urandom}};
        mask_i     = '1;
        commit_i   = 1'b1;
        repeat (3) @(negedge clk);
        in_valid_i = 1'b0;
        commit_i   = 1'b0;
        release_vector();
        @(negedge clk);
        release_vector();

        // Beat running past the end, then an empty commit.
        apply_stimulus(AW'(240), {8{$urandom}}, '1, 1'b0, 1'b0);
        apply_stimulus(AW'(0), '0, '0, 1'b1, 1'b0);
        @(negedge clk);
        release_vector();

        // Refill with a single element and commit.
        beat = '0;
        beat[EW-1:0] = 8'h7F;
        apply_stimulus(AW'(5), beat, 32'h1, 1'b1, 1'b0);
        @(negedge clk);
        release_vector();

        // Commit and release in the same cycle with one bank committed.
        apply_stimulus(AW'(0), {8{$urandom}}, '1, 1'b1, 1'b0);
        apply_stimulus(AW'(32), {8{$urandom}}, '1, 1'b0, 1'b0);
        apply_stimulus(AW'(64), {8{$urandom}}, $urandom, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        release_vector();

        // Random traffic; the consumer is forced to drain when both banks are full.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                out_ready_i = 1'($urandom_range(0, 1));
                @(negedge clk);
                out_ready_i = 1'b0;
            end else begin
                rel = (exp_q.size() == 2) || ($urandom_range(0, 2) == 0);
                apply_stimulus(AW'($urandom_range(0, NE - 1)), {8{$urandom}},
                               ($urandom_range(0, 1) == 1) ? $urandom : ($urandom & $urandom),
                               $urandom_range(0, 4) == 0, rel);
            end
        end

        // Reset in the middle of a fill with a vector waiting.
        while (exp_q.size() > 0) release_vector();
        random_vector(1'b1);
        apply_stimulus(AW'(16), {8{$urandom}}, '1, 1'b0, 1'b0);
        do_reset();
        beat = '0;
        beat[EW-1:0] = 8'hA5;
        apply_stimulus(AW'(200), beat, 32'h1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        while (exp_q.size() > 0) release_vector();
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
